// File: rtl/jtag_dtm.sv
// jtag_dtm: JTAG debug transport module. Oversamples the JTAG pins in the clk
// domain, runs the 1149.1 TAP with IDCODE/DTMCS/DMI/BYPASS data registers and
// turns DMI scans into 4-phase req/ack transactions toward the debug module.
module jtag_dtm #(
   parameter int unsigned DMI_ADDR_BITS = 6,
   parameter int unsigned DMI_DATA_BITS = 32,
   parameter int unsigned DMI_OP_BITS   = 2,
   parameter logic [31:0] IDCODE_VAL    = 32'h1e200a6d,
   parameter int unsigned IR_BITS       = 5,
   localparam int unsigned DMI_BITS     = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                jtag_tck_i,
   input  logic                jtag_tms_i,
   input  logic                jtag_tdi_i,
   output logic                jtag_tdo_o,
   output logic                dtm_req_valid_o,
   output logic [DMI_BITS-1:0] dtm_req_data_o,
   input  logic                dm_ack_i,
   input  logic                dm_resp_valid_i,
   input  logic [DMI_BITS-1:0] dm_resp_data_i,
   output logic                dtm_ack_o
);

   typedef struct packed {
      logic [DMI_ADDR_BITS-1:0] addr;
      logic [DMI_DATA_BITS-1:0] data;
      logic [DMI_OP_BITS-1:0]   op;
   } dmi_t;

   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } tap_e;

   typedef enum logic [1:0] { REQ_IDLE, REQ_WAIT_ACK, REQ_WAIT_LOW } req_e;
   typedef enum logic       { RSP_IDLE, RSP_ACK } rsp_e;

   localparam logic [IR_BITS-1:0] IR_IDCODE = IR_BITS'('h01);
   localparam logic [IR_BITS-1:0] IR_DTMCS  = IR_BITS'('h10);
   localparam logic [IR_BITS-1:0] IR_DMI    = IR_BITS'('h11);

   // standard 1149.1 next-state table
   function automatic tap_e tap_next(input tap_e s, input logic m);
      case (s)
         TLR:     return m ? TLR    : RTI;
         RTI:     return m ? SEL_DR : RTI;
         SEL_DR:  return m ? SEL_IR : CAP_DR;
         CAP_DR:  return m ? EX1_DR : SH_DR;
         SH_DR:   return m ? EX1_DR : SH_DR;
         EX1_DR:  return m ? UPD_DR : PAU_DR;
         PAU_DR:  return m ? EX2_DR : PAU_DR;
         EX2_DR:  return m ? UPD_DR : SH_DR;
         UPD_DR:  return m ? SEL_DR : RTI;
         SEL_IR:  return m ? TLR    : CAP_IR;
         CAP_IR:  return m ? EX1_IR : SH_IR;
         SH_IR:   return m ? EX1_IR : SH_IR;
         EX1_IR:  return m ? UPD_IR : PAU_IR;
         PAU_IR:  return m ? EX2_IR : PAU_IR;
         EX2_IR:  return m ? UPD_IR : SH_IR;
         UPD_IR:  return m ? SEL_DR : RTI;
         default: return TLR;
      endcase
   endfunction

   logic [1:0]          tck_s, tms_s, tdi_s;
   logic                tck_q;
   logic                tck_rise, tck_fall, tms, tdi;
   tap_e                tap_st, tap_nxt;
   logic [IR_BITS-1:0]  ir, ir_shift;
   logic [DMI_BITS-1:0] dr_shift, dr_capture, dr_shifted;
   logic [31:0]         dtmcs_val;
   logic [DMI_OP_BITS-1:0] dmi_status;
   logic                upd_dr, upd_dmi, upd_dtmcs;
   req_e                req_st;
   rsp_e                rsp_st;
   dmi_t                resp_q;
   logic                busy, sticky, dmi_busy;

   // two-flop synchronizers on all pins plus the TCK edge-detect register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tck_s <= '0;
         tms_s <= '0;
         tdi_s <= '0;
         tck_q <= 1'b0;
      end else begin
         tck_s <= {tck_s[0], jtag_tck_i};
         tms_s <= {tms_s[0], jtag_tms_i};
         tdi_s <= {tdi_s[0], jtag_tdi_i};
         tck_q <= tck_s[1];
      end
   end

   assign tck_rise = tck_s[1] & ~tck_q;
   assign tck_fall = ~tck_s[1] & tck_q;
   assign tms      = tms_s[1];
   assign tdi      = tdi_s[1];
   assign tap_nxt  = tap_next(tap_st, tms);

   // update actions fire on the TCK edge that enters the Update state
   assign upd_dr    = tck_rise && (tap_nxt == UPD_DR);
   assign upd_dmi   = upd_dr && (ir == IR_DMI);
   assign upd_dtmcs = upd_dr && (ir == IR_DTMCS);

   // a request still completing its ack phase counts as busy too
   assign dmi_busy   = busy || (req_st != REQ_IDLE);
   assign dmi_status = (dmi_busy || sticky) ? '1 : resp_q.op;
   assign dtmcs_val  = {14'h0, 3'b000, 3'd5, {2{sticky}}, 6'(DMI_ADDR_BITS), 4'd1};

   // capture value and shift-right result for the selected data register
   always_comb begin
      dr_capture = '0;
      dr_shifted = {{(DMI_BITS-1){1'b0}}, tdi};
      case (ir)
         IR_IDCODE: begin
            dr_capture = DMI_BITS'(IDCODE_VAL);
            dr_shifted = DMI_BITS'({tdi, dr_shift[31:1]});
         end
         IR_DTMCS: begin
            dr_capture = DMI_BITS'(dtmcs_val);
            dr_shifted = DMI_BITS'({tdi, dr_shift[31:1]});
         end
         IR_DMI: begin
            dr_capture = {resp_q.addr, resp_q.data, dmi_status};
            dr_shifted = {tdi, dr_shift[DMI_BITS-1:1]};
         end
         default: ;
      endcase
   end

   // TAP state, instruction/data shift registers and TDO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_st     <= TLR;
         ir         <= IR_IDCODE;
         ir_shift   <= '0;
         dr_shift   <= '0;
         jtag_tdo_o <= 1'b0;
      end else begin
         if (tck_rise) begin
            tap_st <= tap_nxt;
            case (tap_st)
               CAP_IR:  ir_shift <= IR_BITS'(1);
               SH_IR:   ir_shift <= {tdi, ir_shift[IR_BITS-1:1]};
               CAP_DR:  dr_shift <= dr_capture;
               SH_DR:   dr_shift <= dr_shifted;
               default: ;
            endcase
            if (tap_nxt == UPD_IR)
               ir <= ir_shift;
            else if (tap_nxt == TLR)
               ir <= IR_IDCODE;
         end
         if (tck_fall) begin
            if (tap_st == SH_IR)
               jtag_tdo_o <= ir_shift[0];
            else if (tap_st == SH_DR)
               jtag_tdo_o <= dr_shift[0];
         end
      end
   end

   // DMI side: request and response handshakes plus busy/sticky bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_st          <= REQ_IDLE;
         rsp_st          <= RSP_IDLE;
         dtm_req_valid_o <= 1'b0;
         dtm_req_data_o  <= '0;
         dtm_ack_o       <= 1'b0;
         resp_q          <= '0;
         busy            <= 1'b0;
         sticky          <= 1'b0;
      end else if (upd_dtmcs && dr_shift[17]) begin
         // dmihardreset: abandon everything in flight
         req_st          <= REQ_IDLE;
         rsp_st          <= RSP_IDLE;
         dtm_req_valid_o <= 1'b0;
         dtm_ack_o       <= 1'b0;
         busy            <= 1'b0;
         sticky          <= 1'b0;
      end else begin
         if (upd_dtmcs && dr_shift[16])
            sticky <= 1'b0;

         case (req_st)
            REQ_WAIT_ACK: if (dm_ack_i) begin
               dtm_req_valid_o <= 1'b0;
               req_st          <= REQ_WAIT_LOW;
            end
            REQ_WAIT_LOW: if (!dm_ack_i) req_st <= REQ_IDLE;
            default:      req_st <= REQ_IDLE;
         endcase

         case (rsp_st)
            RSP_IDLE: if (dm_resp_valid_i) begin
               resp_q    <= dm_resp_data_i;
               dtm_ack_o <= 1'b1;
               rsp_st    <= RSP_ACK;
            end
            default: if (!dm_resp_valid_i) begin
               dtm_ack_o <= 1'b0;
               busy      <= 1'b0;
               rsp_st    <= RSP_IDLE;
            end
         endcase

         // new scan: overlap goes sticky, read/write launches a request
         if (upd_dmi) begin
            if (dmi_busy || sticky) begin
               sticky <= 1'b1;
            end else if (dr_shift[DMI_OP_BITS-1:0] == DMI_OP_BITS'(1) ||
                         dr_shift[DMI_OP_BITS-1:0] == DMI_OP_BITS'(2)) begin
               dtm_req_data_o  <= dr_shift;
               dtm_req_valid_o <= 1'b1;
               busy            <= 1'b1;
               req_st          <= REQ_WAIT_ACK;
            end
         end
      end
   end

endmodule

// File: tb/tb_jtag_dtm.sv
// tb_jtag_dtm: drives JTAG scans through the DTM, models the DM side of both
// handshakes and scores requests and captured DR values against queues.
module tb_jtag_dtm;
   localparam int NB = 40;
   localparam logic [31:0] IDC = 32'h1e200a6d;

   logic clk = 1'b0, rst_n = 1'b0;
   logic jtag_tck_i = 1'b0, jtag_tms_i = 1'b0, jtag_tdi_i = 1'b0;
   logic jtag_tdo_o, dtm_req_valid_o, dtm_ack_o;
   logic dm_ack_i = 1'b0, dm_resp_valid_i = 1'b0;
   logic [NB-1:0] dtm_req_data_o;
   logic [NB-1:0] dm_resp_data_i = '0;

   int errors = 0, checks = 0;
   int n_req = 0, n_done = 0;
   bit dm_en = 1'b1, resp_en = 1'b1;
   logic [NB-1:0] req_q[$];   // requests the DTM must issue
   logic [NB-1:0] rsp_q[$];   // responses the DM model will return
   logic [63:0]   cap_q[$];   // expected DR capture values

   localparam logic [NB-1:0] WR  = {6'h10, 32'h0000_0001, 2'b10};
   localparam logic [NB-1:0] WRR = {6'h10, 32'h0000_0000, 2'b00};
   localparam logic [NB-1:0] RD  = {6'h11, 32'h0000_0000, 2'b01};
   localparam logic [NB-1:0] RDR = {6'h11, 32'h00430c82, 2'b00};

   always #5 clk = ~clk;

   jtag_dtm dut (
      .clk(clk), .rst_n(rst_n),
      .jtag_tck_i(jtag_tck_i), .jtag_tms_i(jtag_tms_i), .jtag_tdi_i(jtag_tdi_i),
      .jtag_tdo_o(jtag_tdo_o),
      .dtm_req_valid_o(dtm_req_valid_o), .dtm_req_data_o(dtm_req_data_o),
      .dm_ack_i(dm_ack_i),
      .dm_resp_valid_i(dm_resp_valid_i), .dm_resp_data_i(dm_resp_data_i),
      .dtm_ack_o(dtm_ack_o)
   );

   // DM model: checks each request, holds ack off for 3 clk, then replies
   initial begin : dm_model
      logic [NB-1:0] got, exp;
      forever begin
         @(negedge clk);
         if (rst_n && dm_en && dtm_req_valid_o && !dm_ack_i) begin
            got = dtm_req_data_o;
            n_req++;
            checks++;
            if (req_q.size() == 0) begin
               errors++; $display("FAIL req_unexpected got=%h", got);
            end else begin
               exp = req_q.pop_front();
               if (got !== exp) begin errors++; $display("FAIL req_data got=%h exp=%h", got, exp); end
            end
            repeat (3) begin
               @(negedge clk);
               checks++;
               if (dtm_req_valid_o !== 1'b1 || dtm_req_data_o !== got) begin
                  errors++; $display("FAIL req_hold valid=%b data=%h exp=1/%h", dtm_req_valid_o, dtm_req_data_o, got);
               end
            end
            dm_ack_i = 1'b1;
            @(negedge clk);
            checks++;
            if (dtm_req_valid_o !== 1'b0) begin errors++; $display("FAIL req_drop valid=%b exp=0", dtm_req_valid_o); end
            dm_ack_i = 1'b0;
            if (resp_en && rsp_q.size() > 0) begin
               dm_resp_data_i  = rsp_q.pop_front();
               dm_resp_valid_i = 1'b1;
               @(negedge clk);
               checks++;
               if (dtm_ack_o !== 1'b1) begin errors++; $display("FAIL rsp_ack_rise ack=%b exp=1", dtm_ack_o); end
               dm_resp_valid_i = 1'b0;
               @(negedge clk);
               checks++;
               if (dtm_ack_o !== 1'b0) begin errors++; $display("FAIL rsp_ack_fall ack=%b exp=0", dtm_ack_o); end
            end
            n_done++;
         end
      end
   end

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
      jtag_tms_i = tms;
      jtag_tdi_i = tdi;
      repeat (5) @(negedge clk);
      tdo = jtag_tdo_o;
      jtag_tck_i = 1'b1;
      repeat (5) @(negedge clk);
      jtag_tck_i = 1'b0;
   endtask

   task automatic tap_reset();
      logic t;
      repeat (5) tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
   endtask

   // from Run-Test/Idle through a DR scan and back; dout[i] is TDO bit i
   task automatic scan_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
      logic t;
      dout = '0;
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      for (int i = 0; i < len; i++) begin
         tck_cycle(i == len - 1, din[i], t);
         dout[i] = t;
      end
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
   endtask

   task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout);
      logic t;
      dout = '0;
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
      for (int i = 0; i < 5; i++) begin
         tck_cycle(i == 4, din[i], t);
         dout[i] = t;
      end
      tck_cycle(1'b1, 1'b0, t);
      tck_cycle(1'b0, 1'b0, t);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({jtag_tdo_o, dtm_req_valid_o, dtm_ack_o} !== 3'b000 || dtm_req_data_o !== '0) begin
         errors++; $display("FAIL reset_outputs tdo/valid/ack=%b%b%b data=%h exp=0", jtag_tdo_o, dtm_req_valid_o, dtm_ack_o, dtm_req_data_o);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_idcode();
      logic [63:0] d, e;
      tap_reset();
      cap_q.push_back({32'h0, IDC});
      scan_dr(32, 64'h0, d);
      e = cap_q.pop_front();
      checks++;
      if (d[31:0] !== e[31:0]) begin errors++; $display("FAIL idcode got=%h exp=%h", d[31:0], e[31:0]); end
   endtask

   task automatic test_dtmcs();
      logic [63:0] d, e;
      logic [4:0]  ic;
      scan_ir(5'h10, ic);
      checks++;
      if (ic !== 5'b00001) begin errors++; $display("FAIL ir_capture got=%b exp=00001", ic); end
      cap_q.push_back(64'h5061);
      scan_dr(32, 64'h0, d);
      e = cap_q.pop_front();
      checks++;
      if (d[31:0] !== e[31:0]) begin errors++; $display("FAIL dtmcs got=%h exp=%h", d[31:0], e[31:0]); end
   endtask

   task automatic test_bypass();
      logic [63:0] d;
      logic [4:0]  ic;
      scan_ir(5'h1f, ic);
      scan_dr(8, 64'hA5, d);
      checks++;
      if (d[7:0] !== 8'h4A) begin errors++; $display("FAIL bypass_1f got=%h exp=4a", d[7:0]); end
      scan_ir(5'h05, ic);
      scan_dr(8, 64'h3C, d);
      checks++;
      if (d[7:0] !== 8'h78) begin errors++; $display("FAIL bypass_undef got=%h exp=78", d[7:0]); end
   endtask

   task automatic test_dmi_write();
      logic [63:0] d, e;
      logic [4:0]  ic;
      int base;
      scan_ir(5'h11, ic);
      base = n_done;
      req_q.push_back(WR);
      rsp_q.push_back(WRR);
      cap_q.push_back(64'h0);
      scan_dr(NB, 64'(WR), d);
      e = cap_q.pop_front();
      checks++;
      if (d[NB-1:0] !== e[NB-1:0]) begin errors++; $display("FAIL dmi_wr_capture got=%h exp=%h", d[NB-1:0], e[NB-1:0]); end
      for (int i = 0; i < 300 && n_done < base + 1; i++) @(negedge clk);
      checks++;
      if (n_done !== base + 1) begin errors++; $display("FAIL dmi_wr_done got=%0d exp=%0d", n_done, base + 1); end
   endtask

   task automatic test_dmi_read();
      logic [63:0] d, e;
      int base, nr;
      base = n_done;
      req_q.push_back(RD);
      rsp_q.push_back(RDR);
      cap_q.push_back(64'(WRR));
      scan_dr(NB, 64'(RD), d);
      e = cap_q.pop_front();
      checks++;
      if (d[NB-1:0] !== e[NB-1:0]) begin errors++; $display("FAIL dmi_rd_capture_prev got=%h exp=%h", d[NB-1:0], e[NB-1:0]); end
      for (int i = 0; i < 300 && n_done < base + 1; i++) @(negedge clk);
      checks++;
      if (n_done !== base + 1) begin errors++; $display("FAIL dmi_rd_done got=%0d exp=%0d", n_done, base + 1); end
      nr = n_req;
      cap_q.push_back(64'(RDR));
      scan_dr(NB, 64'h0, d);
      e = cap_q.pop_front();
      checks++;
      if (d[NB-1:0] !== e[NB-1:0]) begin errors++; $display("FAIL dmi_rd_result got=%h exp=%h", d[NB-1:0], e[NB-1:0]); end
      repeat (10) @(negedge clk);
      checks++;
      if (n_req !== nr || dtm_req_valid_o !== 1'b0) begin errors++; $display("FAIL dmi_nop_issued reqs=%0d exp=%0d", n_req, nr); end
   endtask

   task automatic test_busy_overlap();
      logic [63:0] d, e;
      logic [4:0]  ic;
      int base, nr;
      resp_en = 1'b0;
      base = n_done;
      req_q.push_back({6'h05, 32'h0, 2'b01});
      cap_q.push_back(64'(RDR));
      scan_dr(NB, 64'({6'h05, 32'h0, 2'b01}), d);
      e = cap_q.pop_front();
      checks++;
      if (d[NB-1:0] !== e[NB-1:0]) begin errors++; $display("FAIL busy_first_capture got=%h exp=%h", d[NB-1:0], e[NB-1:0]); end
      for (int i = 0; i < 300 && n_done < base + 1; i++) @(negedge clk);
      checks++;
      if (n_done !== base + 1) begin errors++; $display("FAIL busy_first_done got=%0d exp=%0d", n_done, base + 1); end
      nr = n_req;
      cap_q.push_back(64'({6'h11, 32'h00430c82, 2'b11}));
      scan_dr(NB, 64'({6'h06, 32'h0, 2'b01}), d);
      e = cap_q.pop_front();
      checks++;
      if (d[NB-1:0] !== e[NB-1:0]) begin errors++; $display("FAIL busy_second_capture got=%h exp=%h", d[NB-1:0], e[NB-1:0]); end
      repeat (20) @(negedge clk);
      checks++;
      if (n_req !== nr || dtm_req_valid_o !== 1'b0) begin errors++; $display("FAIL busy_second_issued reqs=%0d exp=%0d", n_req, nr); end
      scan_ir(5'h10, ic);
      cap_q.push_back(64'h5C61);
      cap_q.push_back(64'h5C61);
      cap_q.push_back(64'h5061);
      foreach (cap_q[k]) begin
         if (k > 2) break;
      end
      scan_dr(32, 64'h0, d);
      e = cap_q.pop_front();
      checks++;
      if (d[31:0] !== e[31:0]) begin errors++; $display("FAIL dmistat_sticky got=%h exp=%h", d[31:0], e[31:0]); end
      scan_dr(32, 64'h10000, d);
      e = cap_q.pop_front();
      checks++;
      if (d[31:0] !== e[31:0]) begin errors++; $display("FAIL dmistat_before_clear got=%h exp=%h", d[31:0], e[31:0]); end
      scan_dr(32, 64'h20000, d);
      e = cap_q.pop_front();
      checks++;
      if (d[31:0] !== e[31:0]) begin errors++; $display("FAIL dmistat_cleared got=%h exp=%h", d[31:0], e[31:0]); end
      scan_ir(5'h11, ic);
      cap_q.push_back(64'(RDR));
      scan_dr(NB, 64'h0, d);
      e = cap_q.pop_front();
      checks++;
      if (d[NB-1:0] !== e[NB-1:0]) begin errors++; $display("FAIL hardreset_busy got=%h exp=%h", d[NB-1:0], e[NB-1:0]); end
      resp_en = 1'b1;
   endtask

   task automatic test_reset_mid_request();
      logic [63:0] d, e;
      logic [4:0]  ic;
      logic t;
      logic [NB-1:0] p;
      p = {6'h03, 32'hdeadbeef, 2'b10};
      dm_en = 1'b0;
      cap_q.push_back(64'(RDR));
      scan_dr(NB, 64'(p), d);
      e = cap_q.pop_front();
      checks++;
      if (d[NB-1:0] !== e[NB-1:0]) begin errors++; $display("FAIL midreq_capture got=%h exp=%h", d[NB-1:0], e[NB-1:0]); end
      tap_reset();
      checks++;
      if (dtm_req_valid_o !== 1'b1 || dtm_req_data_o !== p) begin
         errors++; $display("FAIL tlr_keeps_req valid=%b data=%h exp=1/%h", dtm_req_valid_o, dtm_req_data_o, p);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({jtag_tdo_o, dtm_req_valid_o, dtm_ack_o} !== 3'b000 || dtm_req_data_o !== '0) begin
         errors++; $display("FAIL async_reset tdo/valid/ack=%b%b%b data=%h exp=0", jtag_tdo_o, dtm_req_valid_o, dtm_ack_o, dtm_req_data_o);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dm_en = 1'b1;
      repeat (2) @(negedge clk);
      tck_cycle(1'b0, 1'b0, t);
      cap_q.push_back({32'h0, IDC});
      scan_dr(32, 64'h0, d);
      e = cap_q.pop_front();
      checks++;
      if (d[31:0] !== e[31:0]) begin errors++; $display("FAIL reset_ir_idcode got=%h exp=%h", d[31:0], e[31:0]); end
      scan_ir(5'h11, ic);
      cap_q.push_back(64'h0);
      scan_dr(NB, 64'h0, d);
      e = cap_q.pop_front();
      checks++;
      if (d[NB-1:0] !== e[NB-1:0]) begin errors++; $display("FAIL reset_resp_regs got=%h exp=%h", d[NB-1:0], e[NB-1:0]); end
   endtask

   initial begin
      test_reset();
      test_idcode();
      test_dtmcs();
      test_bypass();
      test_dmi_write();
      test_dmi_read();
      test_busy_overlap();
      test_reset_mid_request();
      checks++;
      if (req_q.size() != 0) begin errors++; $display("FAIL req_q_leftover got=%0d exp=0", req_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
